// File: rtl/stream_arb2_pkg.sv
// Shared grant encodings, pointer reset value and counter helper for stream_arb2.
package stream_arb2_pkg;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  // Pointer starts on B so that A wins the very first tie.
  localparam logic LAST_GRANT_RST = GRANT_B;

  function automatic logic [31:0] cnt_max(input int unsigned width);
    if (width >= 32) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-request round-robin picker; ties go to the side not granted last.
module rr_pick2
  import stream_arb2_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant
);

  always_comb begin
    grant = last_grant;
    if (req_a && req_b) begin
      grant = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
    end else if (req_a) begin
      grant = GRANT_A;
    end else if (req_b) begin
      grant = GRANT_B;
    end
  end

endmodule

// File: rtl/stream_arb2.sv
// Two-input round-robin stream arbiter with a one-entry registered output stage.
// Define STREAM_ARB2_STATS_EN to add saturating per-input grant counters.
module stream_arb2
  import stream_arb2_pkg::*;
#(
  parameter int DATA_WIDTH = 7,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic [DATA_WIDTH-1:0] A_DI,
  input  logic                  AValid_SI,
  output logic                  AReady_SO,
  input  logic [DATA_WIDTH-1:0] B_DI,
  input  logic                  BValid_SI,
  output logic                  BReady_SO,
  output logic                  Sel_SO,
  output logic [DATA_WIDTH-1:0] Out_DO,
  output logic                  OutValid_SO,
  input  logic                  OutReady_SI
`ifdef STREAM_ARB2_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  GrantCntA_DO,
  output logic [CNT_WIDTH-1:0]  GrantCntB_DO
`endif
);

  if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_cnt_width
    $error("stream_arb2: CNT_WIDTH must be in 1..32");
  end

  logic last_grant;
  logic grant;
  logic load;
  logic a_hs;
  logic b_hs;

  rr_pick2 u_pick (
    .req_a      (AValid_SI),
    .req_b      (BValid_SI),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign load = !OutValid_SO || OutReady_SI;

  // Readies and select are gated by reset so nothing handshakes while it is held.
  assign a_hs      = Rst_RBI && load && (grant == GRANT_A) && AValid_SI;
  assign b_hs      = Rst_RBI && load && (grant == GRANT_B) && BValid_SI;
  assign AReady_SO = a_hs;
  assign BReady_SO = b_hs;
  assign Sel_SO    = Rst_RBI ? grant : GRANT_A;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      Out_DO      <= '0;
      OutValid_SO <= 1'b0;
      last_grant  <= LAST_GRANT_RST;
    end else if (a_hs || b_hs) begin
      Out_DO      <= (grant == GRANT_B) ? B_DI : A_DI;
      OutValid_SO <= 1'b1;
      last_grant  <= grant;
    end else if (OutReady_SI) begin
      OutValid_SO <= 1'b0;
    end
  end

`ifdef STREAM_ARB2_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      GrantCntA_DO <= '0;
      GrantCntB_DO <= '0;
    end else begin
      if (a_hs && (GrantCntA_DO != CNT_MAX)) GrantCntA_DO <= GrantCntA_DO + CNT_WIDTH'(1);
      if (b_hs && (GrantCntB_DO != CNT_MAX)) GrantCntB_DO <= GrantCntB_DO + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
